// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline-stage register tags and qualifiers in,
// enables, flushes, forwarding selects and perf counters out.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic                  id_uses_rs, id_uses_rt;
  logic                  ex_regwrite, ex_memread, mem_regwrite, mem_access;
  logic                  branch_taken, wb_regwrite;
  logic                  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic                  if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0]            fwd_a, fwd_b;
  logic [CNT_W-1:0]      stall_cnt, flush_cnt;

  // Pipeline side: drives the stage tags, observes the controls.
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_regwrite,
           ex_memread, mem_rd, mem_regwrite, mem_access, branch_taken, wb_rd, wb_regwrite,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
           ex_mem_flush, fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_regwrite,
           ex_memread, mem_rd, mem_regwrite, mem_access, branch_taken, wb_rd, wb_regwrite,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
           ex_mem_flush, fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage IF/ID/EX/MEM/WB pipeline: DMem wait freeze,
// branch-in-MEM flush, load-use bubble, EX forwarding and saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned CNT_W      = 16
) (
  input logic               CLK,
  input logic               RST,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned     WcntW    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam bit              HasWait  = (MEM_LAT >= 2);
  // First MWAIT cycle already counts as stall #2, hence MEM_LAT-2.
  localparam logic [WcntW-1:0] WcntInit = WcntW'((MEM_LAT >= 2) ? (MEM_LAT - 2) : 0);

  typedef enum logic [0:0] {StRun, StMwait} stateT;

  stateT            state;
  logic [WcntW-1:0] wcnt;
  logic [CNT_W-1:0] stallCnt, flushCnt;
  logic             freeze, branchFlush, loadUse, pcEn;

  function automatic logic [1:0] fwdSel(input logic [REG_ADDR_W-1:0] src,
                                        input logic [REG_ADDR_W-1:0] memRd,
                                        input logic                  memWr,
                                        input logic [REG_ADDR_W-1:0] wbRd,
                                        input logic                  wbWr);
    if (memWr && (memRd != '0) && (memRd == src))   return 2'b01;
    else if (wbWr && (wbRd != '0) && (wbRd == src)) return 2'b10;
    else                                            return 2'b00;
  endfunction

  // Hazard classification and pipeline-register control, highest priority first.
  always_comb begin
    if (state == StMwait) freeze = (wcnt != '0);
    else                  freeze = HasWait && bus.mem_access;

    // Release cycle (MWAIT, wcnt==0) falls through as RUN without mem_access retrigger.
    branchFlush = !freeze && bus.branch_taken;
    loadUse     = !freeze && !branchFlush && bus.ex_memread && bus.ex_regwrite &&
                  (bus.ex_rd != '0) &&
                  ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
                   (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));

    pcEn             = 1'b1;
    bus.if_id_en     = 1'b1;
    bus.id_ex_en     = 1'b1;
    bus.ex_mem_en    = 1'b1;
    bus.mem_wb_en    = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    bus.ex_mem_flush = 1'b0;
    bus.fwd_a        = fwdSel(bus.ex_rs, bus.mem_rd, bus.mem_regwrite, bus.wb_rd,
                              bus.wb_regwrite);
    bus.fwd_b        = fwdSel(bus.ex_rt, bus.mem_rd, bus.mem_regwrite, bus.wb_rd,
                              bus.wb_regwrite);

    if (freeze) begin
      pcEn          = 1'b0;
      bus.if_id_en  = 1'b0;
      bus.id_ex_en  = 1'b0;
      bus.ex_mem_en = 1'b0;
      bus.mem_wb_en = 1'b0;
    end else if (branchFlush) begin
      bus.if_id_flush  = 1'b1;
      bus.id_ex_flush  = 1'b1;
      bus.ex_mem_flush = 1'b1;
    end else if (loadUse) begin
      pcEn            = 1'b0;
      bus.if_id_en    = 1'b0;
      bus.id_ex_flush = 1'b1;
    end

    if (RST) begin
      pcEn             = 1'b0;
      bus.if_id_en     = 1'b0;
      bus.id_ex_en     = 1'b0;
      bus.ex_mem_en    = 1'b0;
      bus.mem_wb_en    = 1'b0;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_flush  = 1'b1;
      bus.ex_mem_flush = 1'b1;
      bus.fwd_a        = 2'b00;
      bus.fwd_b        = 2'b00;
    end

    bus.pc_en = pcEn;
  end

  // Wait-state FSM and saturating stall/flush counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= StRun;
      wcnt     <= '0;
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      unique case (state)
        StRun: begin
          if (HasWait && bus.mem_access) begin
            state <= StMwait;
            wcnt  <= WcntInit;
          end
        end
        StMwait: begin
          if (wcnt != '0) wcnt  <= wcnt - WcntW'(1);
          else            state <= StRun;
        end
        default: state <= StRun;
      endcase
      if (!pcEn && (stallCnt != '1))       stallCnt <= stallCnt + CNT_W'(1);
      if (branchFlush && (flushCnt != '1)) flushCnt <= flushCnt + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stallCnt;
  assign bus.flush_cnt = flushCnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard controller for the 5-stage IF/ID/EX/MEM/WB datapath. It adds what the current pipeline lacks:
- load-use stall detection
- branch-taken flush, with the branch resolved in MEM
- EX operand forwarding selects
- multi-cycle data-memory wait sequencing
- saturating stall/flush performance counters

It drives the enable and flush pins of every pipeline register and the PC.

Parameters:
REG_ADDR_W, 5, register-index width
MEM_LAT, 1, data-memory access latency in cycles (1..16); 1 = single-cycle DMem, no wait state
CNT_W, 16, width of each performance counter

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous active-high reset
id_rs  in  REG_ADDR_W  rs of instruction in ID
id_rt  in  REG_ADDR_W  rt of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
ex_rs  in  REG_ADDR_W  rs of instruction in EX
ex_rt  in  REG_ADDR_W  rt of instruction in EX
ex_rd  in  REG_ADDR_W  destination (post RegDst mux) in EX
ex_regwrite  in  1  EX instruction writes register
ex_memread  in  1  EX instruction is a load
mem_rd  in  REG_ADDR_W  destination in MEM
mem_regwrite  in  1  MEM instruction writes register
mem_access  in  1  MEM instruction reads or writes DMem
branch_taken  in  1  Branch AND zero, in MEM
wb_rd  in  REG_ADDR_W  destination in WB
wb_regwrite  in  1  WB instruction writes register
pc_en  out  1  PC load enable
if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register enables
if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  synchronous clear to bubble
fwd_a  out  2  ALU operand A select: 00 regfile, 01 MEM ALU result, 10 WB write data
fwd_b  out  2  ALU operand B select (pre ALUSrc mux), same encoding
stall_cnt  out  CNT_W  cycles with pc_en=0
flush_cnt  out  CNT_W  branch flush events

Behaviour:
- Reset is synchronous and active-high on RST. While RST=1:
  - all enables 0; all three flushes 1; fwd_a = fwd_b = 00
  - on the edge: state<=RUN, wait counter<=0, stall_cnt<=0, flush_cnt<=0
- Reset mid-wait abandons the wait; the first cycle after reset is RUN.
- Register index 0 never matches for hazard or forwarding.
- FSM: RUN, MWAIT. Internal wcnt is clog2(MEM_LAT) bits.
- RUN, mem_access=1, MEM_LAT>=2:
  - freeze: all five enables 0, no flush
  - next state MWAIT, wcnt<=MEM_LAT-2
- MWAIT, wcnt!=0: freeze, wcnt decrements.
- MWAIT, wcnt==0 (release cycle):
  - outputs evaluated as in RUN, but mem_access is ignored (no retrigger)
  - next state RUN
- Total wait stall = MEM_LAT-1 cycles per access. With MEM_LAT=1, MWAIT is unreachable.
- Load-use (RUN or release cycle, no freeze): ex_memread & ex_regwrite & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
  - Response: pc_en=0, if_id_en=0, id_ex_flush=1; other enables 1.
  - Exactly one bubble per hazard.
- Branch taken (RUN or release cycle): if_id_flush=1, id_ex_flush=1, ex_mem_flush=1, pc_en=1. Load-use is suppressed that cycle.
- Priority: freeze > branch > load-use > normal. Normal = all enables 1, flushes 0.
- A branch and a memory wait never coincide on one MEM instruction. Any branch_taken seen during MWAIT is acted on only at release.
- Forwarding is combinational, independent of stalls, and applies per operand (A uses ex_rs, B uses ex_rt):
  - 01 if mem_regwrite & mem_rd!=0 & mem_rd==operand reg
  - else 10 if wb_regwrite & wb_rd!=0 & wb_rd==operand reg
  - else 00
  - MEM match wins over WB match.
- Counters are registered and saturate at all-ones (no wrap):
  - stall_cnt +1 on each cycle with pc_en=0 and RST=0
  - flush_cnt +1 on each branch-flush cycle

Test Plan:
- Reset: RST=1 for 2 cycles with mem_access=1 -> enables 0, flushes 1, fwd 00. After release: counters 0, state RUN, pc_en=1 on first cycle with no hazards.
- Load-use: ex_memread=1, ex_regwrite=1, ex_rd=8, id_rs=8, id_uses_rs=1 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1, then stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- Branch over load-use: branch_taken=1 together with a load-use condition -> if_id/id_ex/ex_mem flush=1, pc_en=1, flush_cnt=1, stall_cnt unchanged.
- Memory wait: MEM_LAT=4, mem_access held 1 -> exactly 3 frozen cycles (all enables 0), then release with enables 1 and no retrigger; stall_cnt=3. MEM_LAT=1 -> zero stalls.
- Forwarding priority: ex_rs=5, mem_rd=5, mem_regwrite=1, wb_rd=5, wb_regwrite=1 -> fwd_a=01. Clear mem_regwrite -> fwd_a=10. ex_rt=0 with all rd=0 -> fwd_b=00.
- Saturation / reset mid-wait: CNT_W=2, 5 load-use stalls -> stall_cnt=3. RST asserted in the 2nd MWAIT cycle -> next cycle in RUN, counters 0.
